// File: rtl/sysid_boot_checker_pkg.sv
// Shared types and helpers for the system-ID boot checker.
// No logic, no ports.
// Provides the address constants, the sequencer/reader state enums and the counter width helper.
package sysid_boot_checker_pkg;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Check sequencer: which word is being fetched.
  typedef enum logic [1:0] {
    S_IDLE,
    S_ID,
    S_TS,
    S_FINISH
  } seq_e;

  // Single-read engine phases. Together with seq_e they form the full check
  // FSM: (S_ID, R_REQ)=REQ_ID, (S_ID, R_LAT)=LAT_ID, (S_TS, R_REQ)=REQ_TS,
  // (S_TS, R_LAT)=LAT_TS, (S_x, R_GAP)=GAP.
  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_LAT,
    R_GAP
  } rd_state_e;

  // Width needed to count 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only bus between the boot checker (master) and system-ID slave.
// No latency of its own; carries address/read out, waitrequest/readdata back.
// Backpressure: the slave stalls the master with avm_waitrequest.
interface sysid_boot_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/sysid_avm_reader.sv
// Single Avalon-MM read engine: issues one read, waits, retries on timeout.
// Latency: read raised the cycle after go; valid on accept (+READ_LATENCY cycles).
// Backpressure: holds avm_read/address while avm_waitrequest is high, up to TIMEOUT cycles.
// Ports: clock/reset_n; go/addr start a read; data+valid pulse the word, fail pulses
// when every retry has timed out; avm is the bus master side.
module sysid_avm_reader
  import sysid_boot_checker_pkg::*;
#(
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT      = 255,
  parameter int MAX_RETRY    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        go,
  input  logic        addr,
  output logic [31:0] data,
  output logic        valid,
  output logic        fail,
  sysid_boot_checker_if.master avm
);

  localparam int TW = cnt_w(TIMEOUT - 1);
  localparam int RW = cnt_w(MAX_RETRY);
  localparam int LW = cnt_w(READ_LATENCY - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [LW-1:0] LAT_LAST  = LW'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  rd_state_e     state_q;
  logic          read_q;
  logic          addr_q;
  logic [TW-1:0] wait_q;
  logic [RW-1:0] retry_q;
  logic [LW-1:0] lat_q;

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;

  // Data is passed through; the caller registers it on valid, so no
  // combinational path reaches any top-level output.
  assign data  = avm.avm_readdata;
  assign valid = ((state_q == R_REQ) && !avm.avm_waitrequest && (READ_LATENCY == 0)) ||
                 ((state_q == R_LAT) && (lat_q == LAT_LAST));
  assign fail  = (state_q == R_REQ) && avm.avm_waitrequest &&
                 (wait_q == WAIT_LAST) && (retry_q == RETRY_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= R_IDLE;
      read_q  <= 1'b0;
      addr_q  <= ADDR_ID;
      wait_q  <= '0;
      retry_q <= '0;
      lat_q   <= '0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (go) begin
            read_q  <= 1'b1;
            addr_q  <= addr;
            wait_q  <= '0;
            retry_q <= '0;
            state_q <= R_REQ;
          end
        end
        R_REQ: begin
          if (!avm.avm_waitrequest) begin
            wait_q <= '0;
            if (READ_LATENCY == 0) begin
              // A follow-on go keeps avm_read high and only moves the address,
              // giving back-to-back reads with no idle cycle.
              if (go) begin
                addr_q  <= addr;
                retry_q <= '0;
              end else begin
                read_q  <= 1'b0;
                state_q <= R_IDLE;
              end
            end else begin
              read_q  <= 1'b0;
              lat_q   <= '0;
              state_q <= R_LAT;
            end
          end else if (wait_q == WAIT_LAST) begin
            read_q <= 1'b0;
            wait_q <= '0;
            if (retry_q == RETRY_MAX) begin
              state_q <= R_IDLE;
            end else begin
              retry_q <= retry_q + RW'(1);
              state_q <= R_GAP;
            end
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        R_LAT: begin
          if (lat_q == LAT_LAST) begin
            if (go) begin
              read_q  <= 1'b1;
              addr_q  <= addr;
              retry_q <= '0;
              state_q <= R_REQ;
            end else begin
              state_q <= R_IDLE;
            end
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
        R_GAP: begin
          read_q  <= 1'b1;
          state_q <= R_REQ;
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads ID (addr 0) and timestamp (addr 1) and compares both.
// Latency: done 3 cycles after start with a zero-wait slave, +2*READ_LATENCY, +stalls, +gaps.
// Backpressure: follows avm_waitrequest; start is ignored while busy.
// Ports: clock/reset_n; start request; avm bus master; busy/done status,
// id_ok/ts_ok/timeout_err verdicts and the captured id_value/ts_value words.
module sysid_boot_checker
  import sysid_boot_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'h5A8C_723F,
  parameter int          READ_LATENCY = 0,
  parameter int          TIMEOUT      = 255,
  parameter int          MAX_RETRY    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  sysid_boot_checker_if.master avm,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  seq_e        state_q;
  logic        busy_q, done_q, id_ok_q, ts_ok_q, terr_q;
  logic [31:0] id_value_q, ts_value_q;

  logic        rd_go, rd_addr, rd_valid, rd_fail;
  logic [31:0] rd_data;

  // go is combinational so the TS read can follow the ID read without a bubble.
  always_comb begin
    rd_go   = 1'b0;
    rd_addr = ADDR_ID;
    case (state_q)
      S_IDLE: rd_go = start;
      S_ID: begin
        rd_go   = rd_valid;
        rd_addr = ADDR_TS;
      end
      default: ;
    endcase
  end

  sysid_avm_reader #(
    .READ_LATENCY(READ_LATENCY),
    .TIMEOUT     (TIMEOUT),
    .MAX_RETRY   (MAX_RETRY)
  ) u_reader (
    .clock  (clock),
    .reset_n(reset_n),
    .go     (rd_go),
    .addr   (rd_addr),
    .data   (rd_data),
    .valid  (rd_valid),
    .fail   (rd_fail),
    .avm    (avm)
  );

  // The verdicts are registered on the edge entering S_FINISH so they are
  // already valid in the done cycle. A read that timed out leaves its flag 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      terr_q     <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q     <= 1'b1;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            terr_q     <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
            state_q    <= S_ID;
          end
        end
        S_ID: begin
          if (rd_valid) begin
            id_value_q <= rd_data;
            state_q    <= S_TS;
          end else if (rd_fail) begin
            terr_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end
        end
        S_TS: begin
          if (rd_valid) begin
            ts_value_q <= rd_data;
            id_ok_q    <= (id_value_q == EXPECTED_ID);
            ts_ok_q    <= (rd_data == EXPECTED_TS);
            done_q     <= 1'b1;
            state_q    <= S_FINISH;
          end else if (rd_fail) begin
            terr_q  <= 1'b1;
            id_ok_q <= (id_value_q == EXPECTED_ID);
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = terr_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: doc/sysid_boot_checker.md
# sysid_boot_checker

Avalon-MM read master that sits directly upstream of the system-ID slave. After `start`, it reads the ID word (address 0) and the timestamp word (address 1) and compares both against build-time expected values. It reports pass/fail to the boot/health logic, with bounded waits, per-read retries and a timeout error.

## Interface
Parameters:
- `EXPECTED_ID`, 32'h0000_0000: expected word at address 0.
- `EXPECTED_TS`, 32'h5A8C_723F: expected word at address 1.
- `READ_LATENCY`, 0: cycles from accepted read (`avm_read` high, `avm_waitrequest` low) to the `avm_readdata` sample; range 0..7.
- `TIMEOUT`, 255: consecutive `avm_waitrequest`-high cycles before a read attempt is abandoned; range 1..65535.
- `MAX_RETRY`, 3: re-issues allowed per read after a timeout; range 0..15.

Ports:
- `clock` in 1: single clock domain.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request to run a check; ignored while `busy`.
- `avm_address` out 1: 0 = ID, 1 = timestamp.
- `avm_read` out 1: read request.
- `avm_waitrequest` in 1: slave stall.
- `avm_readdata` in 32: read data.
- `busy` out 1: a check is in progress.
- `done` out 1: one-cycle pulse at the end of a check.
- `id_ok` out 1: ID matched.
- `ts_ok` out 1: timestamp matched.
- `timeout_err` out 1: a read exhausted its retries.
- `id_value` out 32: captured ID word.
- `ts_value` out 32: captured timestamp word.

## Operation
- Reset values: all outputs 0, including `avm_address`. The FSM resets to IDLE and all counters to 0.
- FSM states: IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, GAP, FINISH.
- IDLE: on `start`, clear `id_ok`, `ts_ok`, `timeout_err`, `id_value` and `ts_value`; go to REQ_ID.
- REQ_x behaviour:
  - Drive `avm_read`=1 and hold `avm_address` stable until the cycle with `avm_waitrequest`=0 (the accept cycle).
  - On accept with `READ_LATENCY`=0: sample `avm_readdata` in that same cycle, then advance.
  - On accept with `READ_LATENCY`>0: deassert `avm_read` and go to LAT_x.
- LAT_x: count `READ_LATENCY` cycles, sample `avm_readdata` in the last one, then advance.
- Advance order: after the ID read go to REQ_TS; after the TS read go to FINISH.
- Timeout:
  - The wait counter increments on every REQ_x cycle with `avm_waitrequest`=1 and resets on accept.
  - When the counter reaches `TIMEOUT`, drop `avm_read`, go to GAP for one cycle, increment the retry count, and re-enter the same REQ_x.
  - If the retry count already equals `MAX_RETRY`: set `timeout_err` and go to FINISH. A failed ID read skips the TS read, and its `*_ok`/`*_value` stay 0.
  - The retry count resets at the start of each read.
- FINISH: `id_ok` = (`id_value` == `EXPECTED_ID`), `ts_ok` = (`ts_value` == `EXPECTED_TS`), pulse `done`, return to IDLE.
- Results hold until the next accepted `start`.
- `busy`=1 in every state except IDLE.
- A `start` coincident with `done` is ignored (the FSM is not yet in IDLE).
- Asserting `reset_n` mid-read drops `avm_read` immediately and discards all results.

## Timing
- Zero-wait slave with `READ_LATENCY`=0, `start` high in cycle N:
  - N+1: `avm_read`=1, address 0.
  - N+2: `avm_read`=1, address 1.
  - N+3: `done`=1, flags valid.
- General case: `done` at N+3+2·`READ_LATENCY`+(stall cycles)+(one GAP cycle per retry).
- `avm_read` is never high for two consecutive accepted cycles at the same address.
- `avm_address` changes only when `avm_read`=0 or in the cycle after an accept.
- All outputs are registered; there is no combinational path from `avm_readdata` to any output.

## Structure
- Package `sysid_boot_checker_pkg`: state enum, `ADDR_ID`=1'b0, `ADDR_TS`=1'b1, counter widths derived from `TIMEOUT`, `MAX_RETRY` and `READ_LATENCY`.
- Sub-module `sysid_avm_reader`: a single-read engine that owns the handshake, latency counter, timeout and retry logic. Its handshake is `go` and `addr` in; `data`, `valid` and `fail` out.
- The top level sequences two reads and performs the comparison.

## Test plan
- Zero-wait slave returning 0 at address 0 and 32'h5A8C_723F at address 1, `start` at N → reads at N+1 and N+2, `done` at N+3, `id_ok`=`ts_ok`=1, `timeout_err`=0.
- Same slave with `READ_LATENCY`=2 → `avm_read` high for exactly one cycle per read, `done` at N+7, correct values captured.
- Slave returns 32'h5A8C_7240 at address 1 → `ts_ok`=0, `id_ok`=1, `ts_value`=32'h5A8C_7240.
- `TIMEOUT`=4, `MAX_RETRY`=1, waitrequest stuck high → two attempts separated by one GAP cycle, `timeout_err`=1, `done` pulse, no TS read issued.
- `start` pulsed while `busy`, and `reset_n` dropped mid-REQ_TS → extra `start` has no effect; after reset, all outputs are 0 and a new `start` completes normally.
